mux_scan_reg: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer. Successor to the combinational 4x1 switch mux.
- Adds two modes:
  - manual select;
  - automatic round-robin scan with a programmable dwell time per channel.
- Adds an output hold/freeze and a channel-change strobe.
- Sits between the board switch inputs and the LED/7-seg display path; also reusable as a generic time-multiplexed channel viewer.

---
 rtl/mux_pkg.sv | 7 +
 rtl/dwell_counter.sv | 18 +
 rtl/mux_scan_reg.sv | 82 ++++++++
 tb/tb_mux_scan_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared state type and channel-wrap helper for mux_scan_reg
package mux_pkg;
  typedef enum logic {MANUAL, SCAN} state_t;
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 1;
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: modulo-DWELL counter with clear/enable and terminal-count flag
// Ports: clk, rst_n (sync, active-low), clr (sync clear), en (count), tc (count == DWELL-1)
module dwell_counter #(
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CW-1:0] cnt;
  assign tc = cnt == CW'(DWELL - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-channel mux with manual select, timed round-robin scan and hold
// Ports: clk, rst_n (sync, active-low), data_in (packed channels), sel (manual select),
//   scan_en (1 = scan), hold (freeze), data_out/ch_out (registered view), ch_change (index
//   changed last edge), sel_err (manual sel out of range)
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      scan_en,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      ch_change,
  output logic                      sel_err
);
  logic [WIDTH-1:0] ch [CHANNELS];
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = data_in[k*WIDTH +: WIDTH];
  end
  state_t state, state_nx;
  logic [SEL_W-1:0] ch_nx;
  logic [WIDTH-1:0] data_nx;
  logic err_nx, cnt_clr, cnt_en, tc, sel_ok;
  assign sel_ok = int'(sel) < CHANNELS;
  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc)
  );
  // hold leaves every next-value equal to the current one, so the register bank simply reloads itself
  always_comb begin
    state_nx = state;
    ch_nx    = ch_out;
    data_nx  = data_out;
    err_nx   = sel_err;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (!hold) begin
      state_nx = scan_en ? SCAN : MANUAL;
      if (state == SCAN && scan_en) begin
        cnt_en  = 1'b1;
        ch_nx   = tc ? SEL_W'(next_idx(int'(ch_out), CHANNELS)) : ch_out;
        data_nx = ch[ch_nx];
        err_nx  = 1'b0;
      end else if (scan_en) begin
        // scan entry: keep the current channel and restart its dwell window
        cnt_clr = 1'b1;
        data_nx = ch[ch_out];
        err_nx  = 1'b0;
      end else begin
        cnt_clr = 1'b1;
        ch_nx   = sel_ok ? sel : ch_out;
        data_nx = sel_ok ? ch[sel] : '0;
        err_nx  = !sel_ok;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= MANUAL;
      data_out  <= '0;
      ch_out    <= '0;
      ch_change <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      data_out  <= data_nx;
      ch_out    <= ch_nx;
      ch_change <= ch_nx != ch_out;
      sel_err   <= err_nx;
    end
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: randomized and directed checks of mux_scan_reg against a behavioural model
module tb_mux_scan_reg;
  localparam int W = 2, D = 3;
  typedef struct {bit scan; int ch; int data; bit err; bit chg; int left;} mdl_t;
  logic clk = 0, rst_n = 0;
  logic [7:0] din4 = 0;
  logic [1:0] sel4 = 0, dout4, ch4;
  logic scan4 = 0, hold4 = 0, chg4, err4;
  logic [5:0] din3 = 0;
  logic [1:0] sel3 = 0, dout3, ch3;
  logic scan3 = 0, hold3 = 0, chg3, err3;
  int errors = 0, checks = 0;
  mdl_t m4, m3;
  always #5 clk = ~clk;
  mux_scan_reg #(.WIDTH(W), .CHANNELS(4), .DWELL(D)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(din4), .sel(sel4), .scan_en(scan4), .hold(hold4),
    .data_out(dout4), .ch_out(ch4), .ch_change(chg4), .sel_err(err4));
  mux_scan_reg #(.WIDTH(W), .CHANNELS(3), .DWELL(D)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(din3), .sel(sel3), .scan_en(scan3), .hold(hold3),
    .data_out(dout3), .ch_out(ch3), .ch_change(chg3), .sel_err(err3));
  // model tracks "cycles left on this channel" rather than a counter
  function automatic mdl_t step(mdl_t m, bit rst, bit hold, bit scan, int sel, int din, int c);
    int old = m.ch;
    if (!rst) begin
      m = '{0, 0, 0, 0, 0, D};
      return m;
    end
    if (hold) begin
      m.chg = 0;
      return m;
    end
    if (scan && m.scan) begin
      m.left--;
      if (m.left == 0) begin
        m.ch = (m.ch + 1) % c;
        m.left = D;
      end
      m.data = (din >> (m.ch * W)) & 3;
      m.err = 0;
    end else if (scan) begin
      m.scan = 1;
      m.left = D;
      m.data = (din >> (m.ch * W)) & 3;
      m.err = 0;
    end else begin
      m.scan = 0;
      if (sel < c) begin
        m.ch = sel;
        m.data = (din >> (sel * W)) & 3;
        m.err = 0;
      end else begin
        m.data = 0;
        m.err = 1;
      end
    end
    m.chg = m.ch != old;
    return m;
  endfunction
  task automatic tick;
    @(posedge clk);
    m4 = step(m4, rst_n, hold4, scan4, int'(sel4), int'(din4), 4);
    m3 = step(m3, rst_n, hold3, scan3, int'(sel3), int'(din3), 3);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0; hold4 = 1; scan4 = 1; hold3 = 1; scan3 = 1; din4 = 8'hE4; din3 = 6'b100111;
    repeat (2) begin
      tick;
      checks++;
      if ({dout4, ch4, chg4, err4} !== 6'b0 || {dout3, ch3, chg3, err3} !== 6'b0) begin
        errors++;
        $display("FAIL reset dut4=%b dut3=%b expected 000000", {dout4, ch4, chg4, err4}, {dout3, ch3, chg3, err3});
      end
    end
    rst_n = 1; hold4 = 0; scan4 = 0; sel4 = 1; hold3 = 0; scan3 = 0; sel3 = 0;
    tick;
    checks++;
    if (dout4 !== 2'd1 || ch4 !== 2'd1 || chg4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release dout=%0d ch=%0d chg=%0d expected 1 1 1", dout4, ch4, chg4);
    end
  endtask
  task automatic test_manual;
    for (int s = 0; s < 4; s++)
      for (int d = 0; d < 256; d++) begin
        din4 = 8'(d); sel4 = 2'(s);
        tick;
        checks++;
        if (dout4 !== 2'((d >> (2 * s)) & 3) || ch4 !== 2'(s) || err4 !== 1'b0) begin
          errors++;
          $display("FAIL manual sel=%0d din=%0d dout=%0d ch=%0d err=%0d expected dout=%0d", s, d, dout4, ch4, err4, (d >> (2 * s)) & 3);
        end
      end
    din4 = 8'hE4; sel4 = 1;
    tick;
    sel4 = 2;
    tick;
    checks++;
    if (ch4 !== 2'd2 || chg4 !== 1'b1 || dout4 !== 2'd2) begin
      errors++;
      $display("FAIL sel_change ch=%0d chg=%0d dout=%0d expected 2 1 2", ch4, chg4, dout4);
    end
    sel4 = 2;
    tick;
    checks++;
    if (chg4 !== 1'b0 || ch4 !== 2'd2) begin
      errors++;
      $display("FAIL sel_rewrite chg=%0d ch=%0d expected 0 2", chg4, ch4);
    end
  endtask
  task automatic test_scan_wrap;
    int exp_d[10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    bit exp_c[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    scan4 = 1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (dout4 !== 2'(exp_d[i]) || chg4 !== exp_c[i]) begin
        errors++;
        $display("FAIL scan_wrap step=%0d dout=%0d chg=%0d expected %0d %0d", i, dout4, chg4, exp_d[i], exp_c[i]);
      end
    end
  endtask
  task automatic test_hold;
    tick;
    hold4 = 1;
    repeat (5) begin
      tick;
      checks++;
      if (dout4 !== 2'd1 || ch4 !== 2'd1 || chg4 !== 1'b0) begin
        errors++;
        $display("FAIL hold dout=%0d ch=%0d chg=%0d expected 1 1 0", dout4, ch4, chg4);
      end
    end
    hold4 = 0;
    tick;
    checks++;
    if (dout4 !== 2'd1 || chg4 !== 1'b0) begin
      errors++;
      $display("FAIL hold_release dout=%0d chg=%0d expected 1 0", dout4, chg4);
    end
    tick;
    checks++;
    if (dout4 !== 2'd2 || ch4 !== 2'd2 || chg4 !== 1'b1) begin
      errors++;
      $display("FAIL hold_advance dout=%0d ch=%0d chg=%0d expected 2 2 1", dout4, ch4, chg4);
    end
  endtask
  task automatic test_mode_switch;
    int n = 0;
    while (ch4 !== 2'd3 && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (ch4 !== 2'd3) begin
      errors++;
      $display("FAIL reach_ch3 ch=%0d expected 3 within 10 cycles", ch4);
    end
    scan4 = 0; sel4 = 0;
    tick;
    checks++;
    if (dout4 !== 2'd0 || ch4 !== 2'd0 || chg4 !== 1'b1) begin
      errors++;
      $display("FAIL to_manual dout=%0d ch=%0d chg=%0d expected 0 0 1", dout4, ch4, chg4);
    end
    tick;
    checks++;
    if (chg4 !== 1'b0) begin
      errors++;
      $display("FAIL to_manual_pulse chg=%0d expected 0", chg4);
    end
    scan4 = 1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (dout4 !== 2'(i == 3) || ch4 !== 2'(i == 3) || chg4 !== (i == 3)) begin
        errors++;
        $display("FAIL to_scan step=%0d dout=%0d ch=%0d chg=%0d expected %0d", i, dout4, ch4, chg4, i == 3);
      end
    end
  endtask
  task automatic test_npow2;
    int exp_c[12] = '{2, 2, 2, 0, 0, 0, 1, 1, 1, 2, 2, 2};
    scan3 = 0; sel3 = 2;
    tick;
    sel3 = 3;
    tick;
    checks++;
    if (dout3 !== 2'd0 || err3 !== 1'b1 || ch3 !== 2'd2 || chg3 !== 1'b0) begin
      errors++;
      $display("FAIL npow2_sel_err dout=%0d err=%0d ch=%0d chg=%0d expected 0 1 2 0", dout3, err3, ch3, chg3);
    end
    scan3 = 1;
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if (ch3 !== 2'(exp_c[i]) || dout3 !== 2'((int'(din3) >> (2 * exp_c[i])) & 3) || err3 !== 1'b0) begin
        errors++;
        $display("FAIL npow2_scan step=%0d ch=%0d dout=%0d err=%0d expected ch=%0d", i, ch3, dout3, err3, exp_c[i]);
      end
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(63) != 0;
      hold4 = $urandom_range(7) == 0;
      hold3 = $urandom_range(7) == 0;
      if ($urandom_range(15) == 0) scan4 = !scan4;
      if ($urandom_range(15) == 0) scan3 = !scan3;
      if ($urandom_range(3) == 0) sel4 = 2'($urandom);
      if ($urandom_range(3) == 0) sel3 = 2'($urandom);
      if ($urandom_range(1) == 0) din4 = 8'($urandom);
      if ($urandom_range(1) == 0) din3 = 6'($urandom);
      tick;
      checks++;
      if ({dout4, ch4, chg4, err4} !== {2'(m4.data), 2'(m4.ch), m4.chg, m4.err} ||
          {dout3, ch3, chg3, err3} !== {2'(m3.data), 2'(m3.ch), m3.chg, m3.err}) begin
        errors++;
        $display("FAIL random cyc=%0d dut4=%0d/%0d/%0d/%0d model4=%0d/%0d/%0d/%0d dut3=%0d/%0d/%0d/%0d model3=%0d/%0d/%0d/%0d",
                 i, dout4, ch4, chg4, err4, m4.data, m4.ch, m4.chg, m4.err,
                 dout3, ch3, chg3, err3, m3.data, m3.ch, m3.chg, m3.err);
      end
    end
  endtask
  initial begin
    test_reset;
    test_manual;
    test_scan_wrap;
    test_hold;
    test_mode_switch;
    test_npow2;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
